rsa_job_sequencer: RTL and testbench
====================================

Name: rsa_job_sequencer

Overview:
- Upstream command stage for the RSA `control` core. It accepts one job per valid/ready handshake: p, q, mode and message.
- It drives the core's two-phase protocol: pulse reset_inverter, wait for inverter_finish, pulse reset_mod_exp, wait for mod_exp_finish.
- It returns msg_out on a valid/ready result port.
- It caches the last key pair so a repeat (p, q) skips the inversion phase. A watchdog aborts hung phases.

Parameters:
- WIDTH, 128: prime width; message and result are 2*WIDTH.
- RST_PULSE, 1: cycles each core reset pulse is held high (>=1).
- TIMEOUT, 65535: max cycles spent in a wait state before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer can accept a job.
- in_p  in  WIDTH  prime p.
- in_q  in  WIDTH  prime q.
- in_encrypt_decrypt  in  1  mode passed to the core.
- in_msg  in  2*WIDTH  message.
- ctl_p, ctl_q  out  WIDTH  primes to the core, held stable for the whole job.
- ctl_encrypt_decrypt  out  1  latched mode.
- ctl_msg_in  out  2*WIDTH  latched message.
- ctl_reset_inverter  out  1  inverter start pulse.
- ctl_reset_mod_exp  out  1  mod-exp start pulse.
- ctl_inverter_finish  in  1  from the core.
- ctl_mod_exp_finish  in  1  from the core.
- ctl_msg_out  in  2*WIDTH  core result.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_msg  out  2*WIDTH  result; 0 on error.
- out_error  out  1  job aborted by watchdog.
- out_key_hit  out  1  inversion was skipped for this job.

Behaviour:
- Reset values:
  - All outputs 0 except in_ready=1.
  - State IDLE; key_valid=0; cached p/q=0; watchdog=0.
- States: IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, DONE.
- IDLE:
  - in_ready=1 only in this state.
  - On in_valid, latch p, q, mode and msg into the ctl_* registers.
  - Go to EXP_RST if key_valid and in_p==cached_p and in_q==cached_q (set hit=1); otherwise go to INV_RST (hit=0).
- INV_RST: ctl_reset_inverter=1 for exactly RST_PULSE cycles, then INV_WAIT.
- INV_WAIT:
  - Sample ctl_inverter_finish every cycle.
  - On 1: cached_p/q <= ctl_p/q, key_valid <= 1, go to EXP_RST.
- EXP_RST: ctl_reset_mod_exp=1 for RST_PULSE cycles, then EXP_WAIT.
- EXP_WAIT: on ctl_mod_exp_finish=1, out_msg <= ctl_msg_out, out_error <= 0, go to DONE.
- DONE:
  - out_valid=1, with out_msg, out_error and out_key_hit stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Finish flags are ignored outside their own wait state. Stale high values during the pulse state are never acted on.
- Watchdog:
  - Clears on entry to INV_WAIT or EXP_WAIT and increments each cycle in that state.
  - If it reaches TIMEOUT without finish: go to DONE with out_error=1, out_msg=0, key_valid <= 0.
  - If finish and timeout coincide, finish wins.
- Latency (RST_PULSE=1, finish asserted on its first sampled cycle), measured from the accept edge T:
  - Miss: out_valid at T+5.
  - Hit: out_valid at T+3.
- ctl_* data outputs change only on accept. They hold their values in DONE and IDLE.
- The key cache compares p/q only; the mode does not invalidate it.
- A reset mid-job returns to IDLE immediately, de-asserts both pulses and invalidates the cache. No result is produced.
- Back-to-back jobs: a job offered while in DONE waits; in_ready rises the cycle after the out handshake.

Decomposition:
- Package rsa_seq_pkg holds:
  - the state enum (6 states, 3 bits);
  - the constant for the 2*WIDTH message width helper.
- One sub-module, rsa_key_cache: holds cached p/q and key_valid, with a compare output, a load strobe and an invalidate strobe.
- The watchdog and pulse counters stay inline.

Test Plan:
- Miss job: p=113680897410347, q=7999808077935876437321, mode 0, msg=0x6a3e18f03ab37b2857000000.
  - Model core finishes 1 cycle after each pulse.
  - Expect one reset_inverter pulse, one reset_mod_exp pulse, out_valid at T+5, out_key_hit=0, out_msg==ctl_msg_out.
- Immediate repeat with the same p/q, msg=0xe7e149, mode 1.
  - Expect no reset_inverter pulse, out_valid at T+3, out_key_hit=1.
- Swapped primes: p=7999808077935876437321, q=113680897410347 after a cached job.
  - Expect a miss (inversion rerun) and the cache updated to the swapped pair.
- Watchdog: TIMEOUT=16, core never raises inverter_finish.
  - Expect out_error=1 and out_msg=0 after 16 wait cycles.
  - The next identical job misses.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Expect out_msg stable and in_ready=0.
  - in_valid is ignored until the handshake.
- Async reset asserted during EXP_WAIT.
  - Expect all outputs at reset values within the same cycle and in_ready=1.
  - The following repeat job misses.

Source files
------------

// File: rtl/rsa_job_sequencer_pkg.sv
// Shared types for the RSA job sequencer: FSM state encoding and message-width helper.
package rsa_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INV_RST  = 3'd1,
    ST_INV_WAIT = 3'd2,
    ST_EXP_RST  = 3'd3,
    ST_EXP_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

  // Messages and results are twice the prime width.
  function automatic int msg_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/rsa_job_sequencer_if.sv
// Job/result handshake bundle between a job producer (master) and the sequencer (slave).
interface rsa_job_sequencer_if #(
  parameter int WIDTH = 128
);
  import rsa_seq_pkg::*;

  localparam int MSG_W = msg_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_q;
  logic             in_encrypt_decrypt;
  logic [MSG_W-1:0] in_msg;

  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_msg;
  logic             out_error;
  logic             out_key_hit;

  modport master (
    output in_valid, in_p, in_q, in_encrypt_decrypt, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_error, out_key_hit
  );

  modport slave (
    input  in_valid, in_p, in_q, in_encrypt_decrypt, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_error, out_key_hit
  );

endinterface

// File: rtl/rsa_job_sequencer_key_cache.sv
// Single-entry (p, q) cache; a hit lets the sequencer skip the modular inversion phase.
module rsa_key_cache #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             invalidate,
  input  logic [WIDTH-1:0] load_p,
  input  logic [WIDTH-1:0] load_q,
  input  logic [WIDTH-1:0] cmp_p,
  input  logic [WIDTH-1:0] cmp_q,
  output logic             hit
);

  logic             key_valid;
  logic [WIDTH-1:0] cached_p;
  logic [WIDTH-1:0] cached_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      cached_p  <= '0;
      cached_q  <= '0;
    end else if (load) begin
      key_valid <= 1'b1;
      cached_p  <= load_p;
      cached_q  <= load_q;
    end else if (invalidate) begin
      key_valid <= 1'b0;
    end
  end

  // Order matters: swapped primes are a different key.
  assign hit = key_valid && (cmp_p == cached_p) && (cmp_q == cached_q);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Command stage for the RSA control core: accepts a job, runs inversion and mod-exp phases
// with a per-phase watchdog, and returns the result on a valid/ready port.
//
// state    | meaning
// IDLE     | in_ready high, waiting for a job
// INV_RST  | holding reset_inverter for RST_PULSE cycles
// INV_WAIT | waiting for inverter_finish (watchdog running)
// EXP_RST  | holding reset_mod_exp for RST_PULSE cycles
// EXP_WAIT | waiting for mod_exp_finish (watchdog running)
// DONE     | result held on out_* until out_ready
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int RST_PULSE = 1,
  parameter int TIMEOUT   = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  rsa_job_sequencer_if.slave          job,
  output logic [WIDTH-1:0]            ctl_p,
  output logic [WIDTH-1:0]            ctl_q,
  output logic                        ctl_encrypt_decrypt,
  output logic [msg_width(WIDTH)-1:0] ctl_msg_in,
  output logic                        ctl_reset_inverter,
  output logic                        ctl_reset_mod_exp,
  input  logic                        ctl_inverter_finish,
  input  logic                        ctl_mod_exp_finish,
  input  logic [msg_width(WIDTH)-1:0] ctl_msg_out
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int PC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(RST_PULSE - 1);

  seq_state_t      state;
  logic [WD_W-1:0] wd;
  logic [PC_W-1:0] pcnt;
  logic            hit_r;
  logic            key_hit;
  logic            key_load;
  logic            key_inval;
  logic            wd_expired;

  assign wd_expired = (wd == WD_LAST);
  assign key_load   = (state == ST_INV_WAIT) && ctl_inverter_finish;
  // A finish arriving on the last watchdog cycle wins over the abort.
  assign key_inval  = wd_expired &&
                      (((state == ST_INV_WAIT) && !ctl_inverter_finish) ||
                       ((state == ST_EXP_WAIT) && !ctl_mod_exp_finish));

  rsa_key_cache #(.WIDTH(WIDTH)) u_key_cache (
    .clk        (clk),
    .reset      (reset),
    .load       (key_load),
    .invalidate (key_inval),
    .load_p     (ctl_p),
    .load_q     (ctl_q),
    .cmp_p      (job.in_p),
    .cmp_q      (job.in_q),
    .hit        (key_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      wd                  <= '0;
      pcnt                <= '0;
      hit_r               <= 1'b0;
      ctl_p               <= '0;
      ctl_q               <= '0;
      ctl_encrypt_decrypt <= 1'b0;
      ctl_msg_in          <= '0;
      ctl_reset_inverter  <= 1'b0;
      ctl_reset_mod_exp   <= 1'b0;
      job.in_ready        <= 1'b1;
      job.out_valid       <= 1'b0;
      job.out_msg         <= '0;
      job.out_error       <= 1'b0;
      job.out_key_hit     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (job.in_valid) begin
            ctl_p               <= job.in_p;
            ctl_q               <= job.in_q;
            ctl_encrypt_decrypt <= job.in_encrypt_decrypt;
            ctl_msg_in          <= job.in_msg;
            job.in_ready        <= 1'b0;
            pcnt                <= '0;
            hit_r               <= key_hit;
            if (key_hit) begin
              ctl_reset_mod_exp <= 1'b1;
              state             <= ST_EXP_RST;
            end else begin
              ctl_reset_inverter <= 1'b1;
              state              <= ST_INV_RST;
            end
          end
        end
        ST_INV_RST: begin
          if (pcnt == PC_LAST) begin
            ctl_reset_inverter <= 1'b0;
            wd                 <= '0;
            state              <= ST_INV_WAIT;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end
        ST_INV_WAIT: begin
          if (ctl_inverter_finish) begin
            ctl_reset_mod_exp <= 1'b1;
            pcnt              <= '0;
            state             <= ST_EXP_RST;
          end else if (wd_expired) begin
            job.out_valid   <= 1'b1;
            job.out_msg     <= '0;
            job.out_error   <= 1'b1;
            job.out_key_hit <= hit_r;
            state           <= ST_DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_EXP_RST: begin
          if (pcnt == PC_LAST) begin
            ctl_reset_mod_exp <= 1'b0;
            wd                <= '0;
            state             <= ST_EXP_WAIT;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end
        ST_EXP_WAIT: begin
          if (ctl_mod_exp_finish) begin
            job.out_valid   <= 1'b1;
            job.out_msg     <= ctl_msg_out;
            job.out_error   <= 1'b0;
            job.out_key_hit <= hit_r;
            state           <= ST_DONE;
          end else if (wd_expired) begin
            job.out_valid   <= 1'b1;
            job.out_msg     <= '0;
            job.out_error   <= 1'b1;
            job.out_key_hit <= hit_r;
            state           <= ST_DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_DONE: begin
          if (job.out_ready) begin
            job.out_valid <= 1'b0;
            job.in_ready  <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer with a small behavioural model of the RSA core.
module tb_rsa_job_sequencer;

  localparam int W     = 128;
  localparam int MW    = 2 * W;
  localparam int TMO   = 16;

  localparam logic [W-1:0]  P1   = 128'd113680897410347;
  localparam logic [W-1:0]  Q1   = 128'd7999808077935876437321;
  localparam logic [MW-1:0] MSG1 = 256'h6a3e18f03ab37b2857000000;
  localparam logic [MW-1:0] MSG2 = 256'he7e149;
  localparam logic [MW-1:0] MSG3 = 256'h1234_5678_9abc_def0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [W-1:0]  ctl_p, ctl_q;
  logic          ctl_encrypt_decrypt;
  logic [MW-1:0] ctl_msg_in;
  logic          ctl_reset_inverter, ctl_reset_mod_exp;
  logic          ctl_inverter_finish = 1'b0;
  logic          ctl_mod_exp_finish = 1'b0;
  logic [MW-1:0] ctl_msg_out = '0;

  bit inv_en = 1'b1;
  bit exp_en = 1'b1;
  int inv_pulses = 0;
  int exp_pulses = 0;

  int errors = 0;
  int checks = 0;

  rsa_job_sequencer_if #(.WIDTH(W)) job_if ();

  rsa_job_sequencer #(.WIDTH(W), .RST_PULSE(1), .TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .job                 (job_if),
    .ctl_p               (ctl_p),
    .ctl_q               (ctl_q),
    .ctl_encrypt_decrypt (ctl_encrypt_decrypt),
    .ctl_msg_in          (ctl_msg_in),
    .ctl_reset_inverter  (ctl_reset_inverter),
    .ctl_reset_mod_exp   (ctl_reset_mod_exp),
    .ctl_inverter_finish (ctl_inverter_finish),
    .ctl_mod_exp_finish  (ctl_mod_exp_finish),
    .ctl_msg_out         (ctl_msg_out)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] core_fn(input logic [W-1:0] p, input logic [W-1:0] q,
                                            input logic m, input logic [MW-1:0] msg);
    return msg ^ {p, q} ^ (m ? {MW{1'b1}} : {MW{1'b0}});
  endfunction

  // Core model: raises each finish one cycle after seeing its start pulse.
  always @(posedge clk) begin
    ctl_inverter_finish <= ctl_reset_inverter && inv_en;
    ctl_mod_exp_finish  <= ctl_reset_mod_exp && exp_en;
    if (ctl_reset_mod_exp)
      ctl_msg_out <= core_fn(ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in);
    if (ctl_reset_inverter) inv_pulses <= inv_pulses + 1;
    if (ctl_reset_mod_exp)  exp_pulses <= exp_pulses + 1;
  end

  // lat counts rising edges including the accept edge until out_valid is seen.
  task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic m,
                         input logic [MW-1:0] msg, output int lat);
    lat = 0;
    @(negedge clk);
    job_if.in_valid = 1'b1;
    job_if.in_p = p;
    job_if.in_q = q;
    job_if.in_encrypt_decrypt = m;
    job_if.in_msg = msg;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    job_if.in_valid = 1'b0;
    while (job_if.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (job_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL job_timeout: out_valid=%0b after %0d cycles, required 1", job_if.out_valid, lat);
    end
  endtask

  task automatic ack_out();
    @(negedge clk);
    job_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (job_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", job_if.in_ready); end
    checks++;
    if ({job_if.out_valid, job_if.out_error, job_if.out_key_hit, ctl_reset_inverter, ctl_reset_mod_exp} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b required 00000",
        {job_if.out_valid, job_if.out_error, job_if.out_key_hit, ctl_reset_inverter, ctl_reset_mod_exp});
    end
    checks++;
    if (job_if.out_msg !== '0 || ctl_p !== '0 || ctl_msg_in !== '0) begin
      errors++; $display("FAIL rst_data: out_msg=%h ctl_p=%h required 0", job_if.out_msg, ctl_p);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (job_if.in_ready !== 1'b1 || job_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst: in_ready=%0b out_valid=%0b required 1/0", job_if.in_ready, job_if.out_valid);
    end
  endtask

  task automatic test_miss();
    int lat, i0, e0;
    i0 = inv_pulses; e0 = exp_pulses;
    run_job(P1, Q1, 1'b0, MSG1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL miss_latency: got %0d required 5", lat); end
    checks++;
    if (inv_pulses - i0 !== 1 || exp_pulses - e0 !== 1) begin
      errors++; $display("FAIL miss_pulses: inv=%0d exp=%0d required 1/1", inv_pulses - i0, exp_pulses - e0);
    end
    checks++;
    if (job_if.out_key_hit !== 1'b0 || job_if.out_error !== 1'b0) begin
      errors++; $display("FAIL miss_flags: hit=%0b err=%0b required 0/0", job_if.out_key_hit, job_if.out_error);
    end
    checks++;
    if (job_if.out_msg !== core_fn(P1, Q1, 1'b0, MSG1)) begin
      errors++; $display("FAIL miss_msg: got %h required %h", job_if.out_msg, core_fn(P1, Q1, 1'b0, MSG1));
    end
    checks++;
    if (ctl_p !== P1 || ctl_q !== Q1 || ctl_msg_in !== MSG1) begin
      errors++; $display("FAIL miss_ctl_hold: ctl_p=%h ctl_q=%h required %h/%h", ctl_p, ctl_q, P1, Q1);
    end
    ack_out();
    checks++;
    if (job_if.out_valid !== 1'b0 || job_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL miss_handshake: out_valid=%0b in_ready=%0b required 0/1", job_if.out_valid, job_if.in_ready);
    end
  endtask

  task automatic test_hit();
    int lat, i0, e0;
    i0 = inv_pulses; e0 = exp_pulses;
    run_job(P1, Q1, 1'b1, MSG2, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL hit_latency: got %0d required 3", lat); end
    checks++;
    if (inv_pulses - i0 !== 0 || exp_pulses - e0 !== 1) begin
      errors++; $display("FAIL hit_pulses: inv=%0d exp=%0d required 0/1", inv_pulses - i0, exp_pulses - e0);
    end
    checks++;
    if (job_if.out_key_hit !== 1'b1 || ctl_encrypt_decrypt !== 1'b1) begin
      errors++; $display("FAIL hit_flags: hit=%0b mode=%0b required 1/1", job_if.out_key_hit, ctl_encrypt_decrypt);
    end
    checks++;
    if (job_if.out_msg !== core_fn(P1, Q1, 1'b1, MSG2)) begin
      errors++; $display("FAIL hit_msg: got %h required %h", job_if.out_msg, core_fn(P1, Q1, 1'b1, MSG2));
    end
    ack_out();
  endtask

  task automatic test_swapped();
    int lat, i0;
    i0 = inv_pulses;
    run_job(Q1, P1, 1'b0, MSG1, lat);
    checks++;
    if (lat !== 5 || inv_pulses - i0 !== 1 || job_if.out_key_hit !== 1'b0) begin
      errors++; $display("FAIL swap_miss: lat=%0d inv=%0d hit=%0b required 5/1/0", lat, inv_pulses - i0, job_if.out_key_hit);
    end
    checks++;
    if (job_if.out_msg !== core_fn(Q1, P1, 1'b0, MSG1)) begin
      errors++; $display("FAIL swap_msg: got %h required %h", job_if.out_msg, core_fn(Q1, P1, 1'b0, MSG1));
    end
    ack_out();
    run_job(Q1, P1, 1'b0, MSG3, lat);
    checks++;
    if (lat !== 3 || job_if.out_key_hit !== 1'b1) begin
      errors++; $display("FAIL swap_cached: lat=%0d hit=%0b required 3/1", lat, job_if.out_key_hit);
    end
    ack_out();
  endtask

  task automatic test_watchdog();
    int lat, e0;
    inv_en = 1'b0;
    e0 = exp_pulses;
    run_job(P1, Q1, 1'b0, MSG1, lat);
    checks++;
    if (lat !== TMO + 2) begin errors++; $display("FAIL wd_inv_latency: got %0d required %0d", lat, TMO + 2); end
    checks++;
    if (job_if.out_error !== 1'b1 || job_if.out_msg !== '0 || exp_pulses - e0 !== 0) begin
      errors++; $display("FAIL wd_inv_result: err=%0b msg=%h exp=%0d required 1/0/0",
        job_if.out_error, job_if.out_msg, exp_pulses - e0);
    end
    ack_out();
    inv_en = 1'b1;
    run_job(P1, Q1, 1'b0, MSG1, lat);
    checks++;
    if (lat !== 5 || job_if.out_key_hit !== 1'b0 || job_if.out_error !== 1'b0) begin
      errors++; $display("FAIL wd_inv_retry: lat=%0d hit=%0b err=%0b required 5/0/0", lat, job_if.out_key_hit, job_if.out_error);
    end
    ack_out();
    // P1/Q1 now cached: hang mod-exp on a hit job, the abort must drop the key.
    exp_en = 1'b0;
    run_job(P1, Q1, 1'b0, MSG2, lat);
    checks++;
    if (lat !== TMO + 2 || job_if.out_error !== 1'b1 || job_if.out_key_hit !== 1'b1 || job_if.out_msg !== '0) begin
      errors++; $display("FAIL wd_exp: lat=%0d err=%0b hit=%0b msg=%h required %0d/1/1/0",
        lat, job_if.out_error, job_if.out_key_hit, job_if.out_msg, TMO + 2);
    end
    ack_out();
    exp_en = 1'b1;
    run_job(P1, Q1, 1'b0, MSG2, lat);
    checks++;
    if (lat !== 5 || job_if.out_key_hit !== 1'b0) begin
      errors++; $display("FAIL wd_exp_retry: lat=%0d hit=%0b required 5/0", lat, job_if.out_key_hit);
    end
    ack_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [MW-1:0] want;
    run_job(P1, Q1, 1'b1, MSG3, lat);
    want = core_fn(P1, Q1, 1'b1, MSG3);
    job_if.in_valid = 1'b1;
    job_if.in_p = 128'd7;
    job_if.in_q = 128'd11;
    job_if.in_msg = MSG1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (job_if.out_valid !== 1'b1 || job_if.out_msg !== want) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%0b msg=%h required 1/%h", i, job_if.out_valid, job_if.out_msg, want);
      end
      checks++;
      if (job_if.in_ready !== 1'b0 || ctl_p !== P1) begin
        errors++; $display("FAIL bp_ignore[%0d]: in_ready=%0b ctl_p=%h required 0/%h", i, job_if.in_ready, ctl_p, P1);
      end
    end
    job_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_if.out_ready = 1'b0;
    job_if.in_valid = 1'b0;
    checks++;
    if (job_if.in_ready !== 1'b1 || job_if.out_valid !== 1'b0 || ctl_p !== P1) begin
      errors++; $display("FAIL bp_release: in_ready=%0b out_valid=%0b ctl_p=%h required 1/0/%h",
        job_if.in_ready, job_if.out_valid, ctl_p, P1);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat;
    exp_en = 1'b0;
    @(negedge clk);
    job_if.in_valid = 1'b1;
    job_if.in_p = P1;
    job_if.in_q = Q1;
    job_if.in_encrypt_decrypt = 1'b0;
    job_if.in_msg = MSG1;
    @(posedge clk);
    @(negedge clk);
    job_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (job_if.in_ready !== 1'b1 || job_if.out_valid !== 1'b0 || ctl_reset_mod_exp !== 1'b0 || ctl_p !== '0) begin
      errors++; $display("FAIL async_reset: in_ready=%0b out_valid=%0b rst_exp=%0b ctl_p=%h required 1/0/0/0",
        job_if.in_ready, job_if.out_valid, ctl_reset_mod_exp, ctl_p);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_en = 1'b1;
    run_job(P1, Q1, 1'b0, MSG1, lat);
    checks++;
    if (lat !== 5 || job_if.out_key_hit !== 1'b0) begin
      errors++; $display("FAIL reset_cache: lat=%0d hit=%0b required 5/0", lat, job_if.out_key_hit);
    end
    ack_out();
  endtask

  initial begin
    job_if.in_valid = 1'b0;
    job_if.in_p = '0;
    job_if.in_q = '0;
    job_if.in_encrypt_decrypt = 1'b0;
    job_if.in_msg = '0;
    job_if.out_ready = 1'b0;
    test_reset();
    test_miss();
    test_hit();
    test_swapped();
    test_watchdog();
    test_backpressure();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
